// File: rtl/tmds_pkg.sv
// tmds_pkg: control-token constants, alignment FSM states and offset width
// shared by the TMDS receive decoder files.
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    localparam int unsigned         OFFSET_W   = 4;
    localparam logic [OFFSET_W-1:0] OFFSET_MAX = 4'd9;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tmds_sym_decode.sv
// tmds_sym_decode: combinational decode of one aligned 10-bit TMDS symbol
// into a control flag/code or an 8-bit pixel byte.
module tmds_sym_decode
    import tmds_pkg::*;
(
    input  logic [9:0] i_aligned,
    output logic       o_is_ctrl,
    output logic [1:0] o_c,
    output logic [7:0] o_d
);

    logic [7:0] w_qm;

    always_comb begin
        o_is_ctrl = 1'b1;
        o_c       = '0;
        o_d       = '0;
        w_qm      = i_aligned[9] ? ~i_aligned[7:0] : i_aligned[7:0];
        case (i_aligned)
            TOK_C00: o_c = 2'b00;
            TOK_C01: o_c = 2'b01;
            TOK_C10: o_c = 2'b10;
            TOK_C11: o_c = 2'b11;
            default: begin
                // bit 8 selects whether the encoder chained bits with XOR or XNOR
                o_is_ctrl = 1'b0;
                o_d[0]    = w_qm[0];
                for (int unsigned i = 1; i < 8; i++) begin
                    o_d[i] = i_aligned[8] ? (w_qm[i] ^ w_qm[i-1]) : ~(w_qm[i] ^ w_qm[i-1]);
                end
            end
        endcase
    end

endmodule

// File: rtl/tmds_dec.sv
// tmds_dec: single-lane TMDS receive decoder with control-token word alignment.
// Define TMDS_DEC_ERRCNT_EN to add the disparity/lock-loss error counter port err_cnt.
module tmds_dec
    import tmds_pkg::*;
#(
    parameter int unsigned CTRL_RUN     = 8,
    parameter int unsigned SEARCH_WIN   = 2048,
    parameter int unsigned LOSS_TIMEOUT = 2048
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          raw,
    output logic [7:0]          d,
    output logic [1:0]          c,
    output logic                de,
    output logic                locked,
`ifdef TMDS_DEC_ERRCNT_EN
    output logic [15:0]         err_cnt,
`endif
    output logic [OFFSET_W-1:0] offset
);

    localparam int unsigned RUN_W   = $clog2(CTRL_RUN + 1);
    localparam int unsigned WIN_W   = $clog2(SEARCH_WIN);
    localparam int unsigned QUIET_W = $clog2(LOSS_TIMEOUT);

    state_t              r_state;
    logic [9:0]          r_w0;
    logic [9:0]          r_w1;
    logic [OFFSET_W-1:0] r_offset;
    logic [RUN_W-1:0]    r_run;
    logic [1:0]          r_last;
    logic [WIN_W-1:0]    r_win;
    logic [QUIET_W-1:0]  r_quiet;
    logic [7:0]          r_d;
    logic [1:0]          r_c;
    logic                r_de;
    logic                r_locked;

    logic [19:0]         w_cat;
    logic [9:0]          w_aligned;
    logic                w_is_ctrl;
    logic [1:0]          w_code;
    logic [7:0]          w_dat;
    logic [RUN_W-1:0]    w_run_next;
    logic                w_lock;
    logic                w_expire;
    logic                w_loss;

    assign w_cat     = {r_w0, r_w1};
    assign w_aligned = w_cat[r_offset +: 10];

    tmds_sym_decode u_dec (
        .i_aligned (w_aligned),
        .o_is_ctrl (w_is_ctrl),
        .o_c       (w_code),
        .o_d       (w_dat)
    );

    always_comb begin
        w_run_next = '0;
        if (w_is_ctrl) begin
            if (r_run != '0 && w_code == r_last) begin
                w_run_next = (r_run == RUN_W'(CTRL_RUN)) ? r_run : r_run + RUN_W'(1);
            end else begin
                w_run_next = RUN_W'(1);
            end
        end
        w_lock   = (w_run_next == RUN_W'(CTRL_RUN));
        w_expire = (r_win == WIN_W'(SEARCH_WIN - 1));
        w_loss   = !w_is_ctrl && (r_quiet == QUIET_W'(LOSS_TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SEARCH;
            r_w0     <= '0;
            r_w1     <= '0;
            r_offset <= '0;
            r_run    <= '0;
            r_last   <= '0;
            r_win    <= '0;
            r_quiet  <= '0;
            r_d      <= '0;
            r_c      <= '0;
            r_de     <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_w0   <= raw;
            r_w1   <= r_w0;
            r_last <= w_code;
            case (r_state)
                SEARCH: begin
                    r_quiet <= '0;
                    r_d     <= '0;
                    r_c     <= '0;
                    r_de    <= 1'b0;
                    // lock takes priority over a window expiry on the same cycle
                    if (w_lock) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                        r_c      <= w_code;
                        r_run    <= '0;
                        r_win    <= '0;
                    end else if (w_expire) begin
                        r_offset <= (r_offset == OFFSET_MAX) ? '0 : r_offset + OFFSET_W'(1);
                        r_run    <= '0;
                        r_win    <= '0;
                    end else begin
                        r_run <= w_run_next;
                        r_win <= r_win + WIN_W'(1);
                    end
                end
                LOCKED: begin
                    if (w_loss) begin
                        r_state  <= SEARCH;
                        r_locked <= 1'b0;
                        r_d      <= '0;
                        r_c      <= '0;
                        r_de     <= 1'b0;
                        r_run    <= '0;
                        r_win    <= '0;
                        r_quiet  <= '0;
                    end else begin
                        r_d  <= w_dat;
                        r_c  <= w_code;
                        r_de <= !w_is_ctrl;
                        if (w_is_ctrl) begin
                            r_quiet <= '0;
                        end else if (r_quiet != '1) begin
                            r_quiet <= r_quiet + QUIET_W'(1);
                        end
                    end
                end
                default: r_state <= SEARCH;
            endcase
        end
    end

    assign d      = r_d;
    assign c      = r_c;
    assign de     = r_de;
    assign locked = r_locked;
    assign offset = r_offset;

`ifdef TMDS_DEC_ERRCNT_EN
    logic signed [5:0] r_disp;
    logic [15:0]       r_err;
    logic [3:0]        w_ones;
    logic signed [6:0] w_delta;
    logic signed [6:0] w_disp_sum;
    logic              w_data_lk;
    logic              w_disp_err;
    logic [1:0]        w_err_inc;
    logic [16:0]       w_err_sum;

    always_comb begin
        w_ones = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            w_ones = w_ones + {3'b000, w_aligned[i]};
        end
        // ones - zeros of a 10-bit symbol is 2*ones - 10
        w_delta    = $signed({2'b00, w_ones, 1'b0}) - 7'sd10;
        w_disp_sum = $signed({r_disp[5], r_disp}) + w_delta;
        w_data_lk  = (r_state == LOCKED) && !w_is_ctrl;
        w_disp_err = w_data_lk && ((w_disp_sum > 7'sd10) || (w_disp_sum < -7'sd10));
        w_err_inc  = {1'b0, w_disp_err} + {1'b0, (r_state == LOCKED) && w_loss};
        w_err_sum  = {1'b0, r_err} + {15'b0, w_err_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= '0;
            r_err  <= '0;
        end else begin
            r_err <= w_err_sum[16] ? '1 : w_err_sum[15:0];
            if (!w_data_lk || w_disp_err) begin
                r_disp <= '0;
            end else begin
                r_disp <= w_disp_sum[5:0];
            end
        end
    end

    assign err_cnt = r_err;
`endif

endmodule

// File: tb/tb_tmds_dec.sv
// tb_tmds_dec: randomized scoreboard bench for tmds_dec against a behavioural
// reference model (decode by inverting the TMDS encoder; alignment by rule).
module tb_tmds_dec;

    localparam int CTRL_RUN     = 8;
    localparam int SEARCH_WIN   = 2048;
    localparam int LOSS_TIMEOUT = 2048;

    localparam logic [9:0] T0 = 10'b1101010100;
    localparam logic [9:0] T1 = 10'b0010101011;
    localparam logic [9:0] T2 = 10'b0101010100;
    localparam logic [9:0] T3 = 10'b1010101011;
    // T0 repeated as a serial stream but starting 3 bits into each word
    localparam logic [9:0] W_SLIP = 10'b1010100110;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] raw   = '0;
    logic [7:0] d;
    logic [1:0] c;
    logic       de;
    logic       locked;
    logic [3:0] offset;
`ifdef TMDS_DEC_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] c;
        logic       de;
        logic       locked;
        logic [3:0] off;
    } out_t;

    out_t        exp_q[$];
    logic [15:0] err_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    logic [9:0] m_h1, m_h2;
    bit         m_lock;
    int         m_off, m_run, m_last, m_win, m_quiet, m_disp, m_err;

    always #5 clk = ~clk;

    tmds_dec #(
        .CTRL_RUN     (CTRL_RUN),
        .SEARCH_WIN   (SEARCH_WIN),
        .LOSS_TIMEOUT (LOSS_TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw     (raw),
        .d       (d),
        .c       (c),
        .de      (de),
        .locked  (locked),
`ifdef TMDS_DEC_ERRCNT_EN
        .err_cnt (err_cnt),
`endif
        .offset  (offset)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tok_code(input logic [9:0] a);
        if (a == T0) return 0;
        if (a == T1) return 1;
        if (a == T2) return 2;
        if (a == T3) return 3;
        return -1;
    endfunction

    // find the byte whose transition-minimised encoding gives this symbol
    function automatic logic [7:0] data_of(input logic [9:0] a);
        logic [7:0] qm, q, x;
        qm = a[9] ? ~a[7:0] : a[7:0];
        for (int v = 0; v < 256; v++) begin
            x    = 8'(v);
            q[0] = x[0];
            for (int i = 1; i < 8; i++) q[i] = a[8] ? (q[i-1] ^ x[i]) : ~(q[i-1] ^ x[i]);
            if (q == qm) return x;
        end
        return 8'h00;
    endfunction

    function automatic int popc(input logic [9:0] a);
        int n = 0;
        for (int i = 0; i < 10; i++) n += int'(a[i]);
        return n;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] r;
        do r = 10'($urandom); while (tok_code(r) >= 0);
        return r;
    endfunction

    function automatic logic [9:0] rand_tok();
        case ($urandom_range(0, 3))
            0: return T0;
            1: return T1;
            2: return T2;
            default: return T3;
        endcase
    endfunction

    task automatic m_reset();
        m_h1 = '0; m_h2 = '0; m_lock = 0;
        m_off = 0; m_run = 0; m_last = -1; m_win = 0; m_quiet = 0; m_disp = 0; m_err = 0;
    endtask

    // predicts the outputs after the next rising edge, given raw and rst_n for it
    task automatic model_step(input logic [9:0] r, input logic rn);
        logic [19:0] s;
        logic [9:0]  a;
        int          code;
        out_t        e;
        e = '0;
        if (!rn) begin
            m_reset();
            exp_q.push_back(e);
`ifdef TMDS_DEC_ERRCNT_EN
            err_q.push_back(16'h0);
`endif
            return;
        end
        s    = {m_h1, m_h2};
        a    = s[m_off +: 10];
        code = tok_code(a);
        if (!m_lock) begin
            if (code < 0) m_run = 0;
            else if (m_run > 0 && code == m_last) m_run++;
            else m_run = 1;
            m_last = code;
            if (m_run == CTRL_RUN) begin
                m_lock = 1; m_run = 0; m_win = 0; m_quiet = 0;
                e.c = 2'(code);
            end else if (m_win == SEARCH_WIN - 1) begin
                m_off = (m_off == 9) ? 0 : m_off + 1;
                m_run = 0; m_win = 0;
            end else begin
                m_win++;
            end
        end else begin
            if (code < 0) begin
                m_disp += 2 * popc(a) - 10;
                if (m_disp > 10 || m_disp < -10) begin m_err++; m_disp = 0; end
            end else begin
                m_disp = 0;
            end
            if (code < 0 && m_quiet == LOSS_TIMEOUT - 1) begin
                m_lock = 0; m_run = 0; m_win = 0; m_quiet = 0; m_err++;
            end else if (code >= 0) begin
                m_quiet = 0;
                e.c = 2'(code);
            end else begin
                m_quiet++;
                e.de = 1'b1;
                e.d  = data_of(a);
            end
        end
        if (!m_lock) m_disp = 0;
        e.locked = m_lock;
        e.off    = 4'(m_off);
        exp_q.push_back(e);
`ifdef TMDS_DEC_ERRCNT_EN
        err_q.push_back((m_err > 65535) ? 16'hFFFF : 16'(m_err));
`endif
        m_h2 = m_h1;
        m_h1 = r;
    endtask

    task automatic drive_rst(input logic [9:0] r, input logic rn);
        @(negedge clk);
        rst_n = rn;
        raw   = r;
        model_step(r, rn);
    endtask

    task automatic drive(input logic [9:0] r);
        drive_rst(r, 1'b1);
    endtask

    task automatic mix(input int n, input int tok_div);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, tok_div - 1) == 0) drive(rand_tok());
            else drive(rand_data());
        end
    endtask

    out_t        mon_e;
    logic [15:0] mon_err;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("out{d,c,de,locked,offset}", 32'({d, c, de, locked, offset}), 32'(mon_e));
`ifdef TMDS_DEC_ERRCNT_EN
                mon_err = err_q.pop_front();
                check("err_cnt", 32'(err_cnt), 32'(mon_err));
`else
                mon_err = 16'h0;
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        got = 0;
        m_reset();

        repeat (5) drive_rst(10'($urandom), 1'b0);
        check("reset_out", 32'({d, c, de, locked, offset}), 32'd0);

        mix(200, 4);
        check("search_unlocked", 32'(locked), 32'd0);

        repeat (3) drive(rand_data());
        repeat (8) drive(T0);
        repeat (2) drive(T0);
        check("lock_not_early", 32'(locked), 32'd0);
        drive(T0);
        check("lock_aligned", 32'({locked, de, c, offset}), 32'({1'b1, 1'b0, 2'b00, 4'd0}));

        drive(10'b0100000000);
        drive(10'b1000000000);
        drive(T2);
        repeat (3) drive(rand_data());
        check("ctrl_10", 32'({de, c, d}), 32'({1'b0, 2'b10, 8'h00}));

        mix(300, 8);

        drive(T1);
        repeat (LOSS_TIMEOUT - 1) drive(rand_data());
        drive(T1);
        repeat (3) drive(rand_data());
        check("token_at_timeout_keeps_lock", 32'(locked), 32'd1);

        drive(T1);
        repeat (LOSS_TIMEOUT) drive(rand_data());
        repeat (2) drive(W_SLIP);
        check("loss_not_early", 32'(locked), 32'd1);
        drive(W_SLIP);
        check("loss_of_lock", 32'({locked, offset}), 32'({1'b0, 4'd0}));

        for (int k = 0; k < 3 * SEARCH_WIN + 40; k++) begin
            drive(W_SLIP);
            if (locked === 1'b1) begin
                got = 1;
                break;
            end
        end
        check("slip_lock", 32'(got), 32'd1);
        check("slip_offset", 32'(offset), 32'd3);
        repeat (20) drive(W_SLIP);
        check("slip_hold", 32'({locked, offset}), 32'({1'b1, 4'd3}));

        @(negedge clk);
        raw   = rand_data();
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'({locked, offset, de}), 32'd0);
        model_step(raw, 1'b0);

        repeat (3) drive(rand_data());
        repeat (8) drive(T3);
        repeat (3) drive(T3);
        check("relock", 32'({locked, c, offset}), 32'({1'b1, 2'b11, 4'd0}));

        mix(50, 6);

        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
